// File: rtl/tone_generator.sv
// -----------------------------------------------------------------------------
// tone_generator
//   Playback stage behind the music memory. Takes a note word (octave:note),
//   looks up the half-period of the pitch and drives a 50% duty square wave on
//   the buzzer pin while the note is held valid.
//
//   Optional feature macro: TONE_VOLUME_EN
//     defined   -> adds the 3-bit 'vol' port and gates the high half of the
//                  tone with a free-running 1-in-8 PWM (vol=7 is full tone)
//     undefined -> no 'vol' port, speaker is the raw tone
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tone_generator #(
  parameter int unsigned NOTE_W = 4,
  parameter int unsigned OCT_W  = 2,
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned CNT_W  = 18
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NOTE_W+OCT_W-1:0]  note_in,
  input  logic                     note_valid,
`ifdef TONE_VOLUME_EN
  input  logic [2:0]               vol,
`endif
  output logic                     speaker,
  output logic                     playing,
  output logic [NOTE_W+OCT_W-1:0]  cur_note
);

  localparam int unsigned WORD_W    = NOTE_W + OCT_W;
  localparam int unsigned ROM_DEPTH = 1 << NOTE_W;

  // Player states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_TONE = 2'd2;
  localparam logic [1:0] ST_REST = 2'd3;

  // Fourth-octave equal-temperament pitch in milli-hertz; 0 marks a rest code.
  function automatic logic [63:0] pitch_mhz(input int unsigned code);
    logic [63:0] f;
    case (code)
      1:       f = 64'd261626;  // C4
      2:       f = 64'd277183;  // C#4
      3:       f = 64'd293665;  // D4
      4:       f = 64'd311127;  // D#4
      5:       f = 64'd329628;  // E4
      6:       f = 64'd349228;  // F4
      7:       f = 64'd369994;  // F#4
      8:       f = 64'd391995;  // G4
      9:       f = 64'd415305;  // G#4
      10:      f = 64'd440000;  // A4
      11:      f = 64'd466164;  // A#4
      12:      f = 64'd493883;  // B4
      default: f = 64'd0;
    endcase
    return f;
  endfunction

  // Rounded half-period in clock cycles: round(CLK_HZ / (2*f)), integer only.
  function automatic logic [CNT_W-1:0] half_calc(input int unsigned code);
    logic [63:0] f;
    logic [63:0] num;
    f = pitch_mhz(code);
    if (f == 64'd0) begin
      num = 64'd0;
    end else begin
      num = (64'(CLK_HZ) * 64'd1000 + f) / (64'd2 * f);
    end
    return num[CNT_W-1:0];
  endfunction

  // Codes 1..12 are pitched; 0 and 13..15 are rests.
  function automatic logic is_pitched(input logic [NOTE_W-1:0] code);
    return (code >= NOTE_W'(1)) && (code <= NOTE_W'(12));
  endfunction

  // Constant half-period table, one entry per note code (rests hold 0).
  logic [CNT_W-1:0] rom_half [ROM_DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < ROM_DEPTH; gi++) begin : g_rom
      assign rom_half[gi] = half_calc(gi);
    end
  endgenerate

  logic [1:0]        state_q,    state_d;
  logic [WORD_W-1:0] cur_note_q, cur_note_d;
  logic [CNT_W-1:0]  half_q,     half_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  logic              tone_q,     tone_d;
  logic [CNT_W-1:0]  rom_word;

  // Octave lookup: each octave up halves the C4-row half-period.
  always_comb begin
    rom_word = rom_half[cur_note_q[NOTE_W-1:0]] >> cur_note_q[WORD_W-1:NOTE_W];
  end

  // Next-state logic: note acceptance, tone phase counting and output level.
  always_comb begin
    state_d    = state_q;
    cur_note_d = cur_note_q;
    half_d     = half_q;
    cnt_d      = cnt_q;
    tone_d     = tone_q;

    // The lookup result is only consumed on the LOAD -> TONE transition.
    if (state_q == ST_LOAD) begin
      half_d = rom_word;
    end

    if (state_q == ST_IDLE) begin
      tone_d = 1'b0;
      cnt_d  = '0;
      if (note_valid) begin
        cur_note_d = note_in;
        state_d    = is_pitched(note_in[NOTE_W-1:0]) ? ST_LOAD : ST_REST;
      end
    end else if (!note_valid) begin
      // Losing valid dominates any simultaneous note change.
      state_d = ST_IDLE;
      tone_d  = 1'b0;
      cnt_d   = '0;
    end else if (note_in != cur_note_q) begin
      // New note: restart from silence, no phase continuity.
      cur_note_d = note_in;
      state_d    = is_pitched(note_in[NOTE_W-1:0]) ? ST_LOAD : ST_REST;
      tone_d     = 1'b0;
      cnt_d      = '0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          state_d = ST_TONE;
          tone_d  = 1'b1;
          cnt_d   = '0;
        end
        ST_TONE: begin
          // '>=' keeps the counter bounded even if half_q were ever stale.
          if (cnt_q >= half_q - CNT_W'(1)) begin
            cnt_d  = '0;
            tone_d = ~tone_q;
          end else begin
            cnt_d  = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          tone_d = 1'b0;
          cnt_d  = '0;
        end
      endcase
    end
  end

  // State registers; reset forces the buzzer low immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cur_note_q <= '0;
      half_q     <= '0;
      cnt_q      <= '0;
      tone_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_note_q <= cur_note_d;
      half_q     <= half_d;
      cnt_q      <= cnt_d;
      tone_q     <= tone_d;
    end
  end

  assign playing  = (state_q == ST_TONE);
  assign cur_note = cur_note_q;

`ifdef TONE_VOLUME_EN
  logic [2:0] pwm_q;

  // Free-running PWM phase used to thin out the high half of the tone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_q <= 3'd0;
    end else begin
      pwm_q <= pwm_q + 3'd1;
    end
  end

  assign speaker = tone_q & (pwm_q <= vol);
`else
  assign speaker = tone_q;
`endif

endmodule

// File: tb/tb_tone_generator.sv
// -----------------------------------------------------------------------------
// tb_tone_generator
//   Directed scenarios followed by randomized note sequences, every cycle
//   compared against a behavioural model that predicts the waveform from the
//   note acceptance time and the pitch formula. Honours TONE_VOLUME_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_tone_generator;

  localparam int unsigned TB_CLK = 100_000;  // small clock keeps periods short

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] note_in;
  logic       note_valid;
  logic       speaker;
  logic       playing;
  logic [5:0] cur_note;
`ifdef TONE_VOLUME_EN
  logic [2:0] vol;
`endif

  tone_generator #(
    .NOTE_W (4),
    .OCT_W  (2),
    .CLK_HZ (TB_CLK),
    .CNT_W  (18)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .note_in    (note_in),
    .note_valid (note_valid),
`ifdef TONE_VOLUME_EN
    .vol        (vol),
`endif
    .speaker    (speaker),
    .playing    (playing),
    .cur_note   (cur_note)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         cyc;       // clock edges since reset release
  bit         m_active;  // a note is being held valid
  logic [5:0] m_cur;
  int         m_accept;  // edge count at which current note was captured

  function automatic bit pitched(input logic [5:0] w);
    return (w[3:0] >= 4'd1) && (w[3:0] <= 4'd12);
  endfunction

  function automatic int model_half(input logic [5:0] w);
    real f;
    int  h;
    f = 440.0 * (2.0 ** (real'(int'(w[3:0]) - 10) / 12.0));
    h = $rtoi(real'(TB_CLK) / (2.0 * f) + 0.5);
    return h >> w[5:4];
  endfunction

  task automatic model_update();
    if (!rst_n) begin
      m_active = 1'b0;
      m_cur    = '0;
      cyc      = 0;
    end else begin
      cyc++;
      if (!note_valid) begin
        m_active = 1'b0;
      end else if (!m_active || note_in != m_cur) begin
        m_active = 1'b1;
        m_cur    = note_in;
        m_accept = cyc;
      end
    end
  endtask

  task automatic compare_outputs();
    bit exp_play;
    bit exp_spk;
    exp_play = m_active && pitched(m_cur) && (cyc >= m_accept + 1);
    exp_spk  = exp_play && ((((cyc - m_accept - 1) / model_half(m_cur)) % 2) == 0);
`ifdef TONE_VOLUME_EN
    exp_spk  = exp_spk && ((cyc % 8) <= int'(vol));
`endif
    check_eq("speaker",  {31'd0, speaker}, {31'd0, exp_spk});
    check_eq("playing",  {31'd0, playing}, {31'd0, exp_play});
    check_eq("cur_note", {26'd0, cur_note}, {26'd0, m_cur});
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic apply(input logic [5:0] w, input logic v, input int len);
    note_in    = w;
    note_valid = v;
    $display("txn note=%02h valid=%0d cycles=%0d", w, v, len);
    repeat (len) step();
  endtask

  task automatic reset_pulse(input string tag);
    #2 rst_n = 1'b0;
    #1;
    check_eq({tag, "_speaker"},  {31'd0, speaker}, 32'd0);
    check_eq({tag, "_playing"},  {31'd0, playing}, 32'd0);
    check_eq({tag, "_cur_note"}, {26'd0, cur_note}, 32'd0);
    m_active = 1'b0;
    m_cur    = '0;
    cyc      = 0;
    repeat (2) step();
    rst_n = 1'b1;
    $display("txn reset pulse %s", tag);
  endtask

  initial begin
    logic [5:0] w;
    int         r;
    rst_n      = 1'b0;
    note_in    = '0;
    note_valid = 1'b0;
    m_active   = 1'b0;
    m_cur      = '0;
    m_accept   = 0;
    cyc        = 0;
`ifdef TONE_VOLUME_EN
    vol        = 3'd7;
`endif
    #3;
    check_eq("rst_speaker",  {31'd0, speaker}, 32'd0);
    check_eq("rst_playing",  {31'd0, playing}, 32'd0);
    check_eq("rst_cur_note", {26'd0, cur_note}, 32'd0);
    repeat (2) step();
    rst_n = 1'b1;

    // Idle, then A4 across octaves
    apply(6'h00, 1'b0, 100);
    apply(6'h0A, 1'b1, 1);
    check_eq("lat_load_speaker", {31'd0, speaker}, 32'd0);
    apply(6'h0A, 1'b1, 1);
    check_eq("lat_tone_speaker", {31'd0, speaker}, 32'd1);
    apply(6'h0A, 1'b1, 300);
    apply(6'h1A, 1'b1, 200);
    apply(6'h3A, 1'b1, 80);

    // Mid-tone switch to rest codes
    apply(6'h0A, 1'b1, 150);
    apply(6'h00, 1'b1, 20);
    apply(6'h0D, 1'b1, 20);
    check_eq("rest13_cur_note", {26'd0, cur_note}, 32'h0D);

    // Valid drop, then reset while tone is high
    apply(6'h0A, 1'b1, 150);
    apply(6'h0A, 1'b0, 10);
    apply(6'h05, 1'b1, 60);
    reset_pulse("midtone");
    apply(6'h0C, 1'b1, 120);

`ifdef TONE_VOLUME_EN
    vol = 3'd0;
    apply(6'h0A, 1'b1, 200);
    vol = 3'd7;
    apply(6'h0A, 1'b1, 200);
`endif

    // Randomized note sequences
    for (int s = 0; s < 30; s++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      w = {2'($urandom_range(0, 3)), 4'd0};
      else if (r == 1) w = {2'($urandom_range(0, 3)), 4'($urandom_range(13, 15))};
      else             w = {2'($urandom_range(0, 3)), 4'($urandom_range(1, 12))};
      if ($urandom_range(0, 4) == 0) w = note_in;
`ifdef TONE_VOLUME_EN
      vol = 3'($urandom_range(0, 7));
`endif
      apply(w, ($urandom_range(0, 5) != 0), int'($urandom_range(20, 600)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
